// File: rtl/tick_counter_ctrl_pkg.sv
// Shared state encoding and default widths for the board counter run-control block.
package tick_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int unsigned DEF_DIV_W = 28;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_DIV   = 8000000;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable timebase on clk_in: counts 0..div-1 while enabled.
// tick flags the terminal phase; the parent decides whether that phase is consumed.
module tick_prescaler
  import tick_counter_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // div is never below 1, so div-1 cannot underflow
  assign tick = (cnt >= (div - DIV_W'(1)));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tick_counter_ctrl.sv
// Run-control sequencer: IDLE/RUN/PAUSE FSM stepping an up/down display counter
// on single-cycle prescaler ticks; all logic stays on clk_in.
module tick_counter_ctrl
  import tick_counter_ctrl_pkg::*;
#(
  parameter int unsigned      DIV_W       = DEF_DIV_W,
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEF_DIV)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [CNT_W-1:0] max_value,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             wrap,
  output logic             done
);

  localparam logic [DIV_W-1:0] RESET_DIV =
    (DEFAULT_DIV < DIV_W'(2)) ? DIV_W'(1) : DEFAULT_DIV;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_reg;
  logic             term;
  logic             pre_en, pre_clr;
  logic [CNT_W-1:0] count_nx;
  logic             tick_nx, wrap_nx, done_nx;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (pre_en),
    .clr    (pre_clr),
    .div    (div_reg),
    .tick   (term)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    tick_nx  = 1'b0;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;
    pre_en   = 1'b0;
    pre_clr  = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
      count_nx = '0;
      pre_clr  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!stop && start) begin
            state_nx = S_RUN;
            pre_clr  = 1'b1;
          end
        end
        S_RUN: begin
          // stop freezes the prescaler, except that a terminal phase is still consumed
          pre_en = !stop || term;
          if (stop) state_nx = S_PAUSE;
          if (term) begin
            tick_nx = 1'b1;
            if (up_down) begin
              if (count < max_value) begin
                count_nx = count + CNT_W'(1);
              end else if (one_shot) begin
                count_nx = max_value;
                done_nx  = 1'b1;
              end else begin
                count_nx = '0;
                wrap_nx  = 1'b1;
              end
            end else begin
              if (count != '0) begin
                count_nx = count - CNT_W'(1);
              end else if (one_shot) begin
                count_nx = '0;
                done_nx  = 1'b1;
              end else begin
                count_nx = max_value;
                wrap_nx  = 1'b1;
              end
            end
            if (done_nx) state_nx = S_IDLE;
          end
        end
        S_PAUSE: begin
          if (!stop && start) state_nx = S_RUN;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
      paused  <= 1'b0;
      div_reg <= RESET_DIV;
    end else begin
      count   <= count_nx;
      tick    <= tick_nx;
      wrap    <= wrap_nx;
      done    <= done_nx;
      running <= (state_nx == S_RUN);
      paused  <= (state_nx == S_PAUSE);
      if (state == S_IDLE && div_load)
        div_reg <= (div_value < DIV_W'(2)) ? DIV_W'(1) : div_value;
    end
  end

endmodule
